// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchronize, debounce, invert and edge-capture
// board inputs, with a maskable level interrupt and write-1-to-clear captures.
module pio_input_capture #(
    parameter int          WIDTH           = 10,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] INVERT_MASK     = '0,
    parameter int          EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] INV = INVERT_MASK[WIDTH-1:0];

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr_mask;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Upper write-data bits have no backing storage when WIDTH < 32.
    assign unused_wdata = ^avs_writedata;

    // Two-flop synchronizer on the asynchronous board inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ INV;

    // Per-bit debounce: accept a new level only after it holds long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge polarity selection on the debounced level.
    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 1) begin
            edge_det = ~stable & stable_d;
        end else if (EDGE_TYPE == 2) begin
            edge_det = stable ^ stable_d;
        end else begin
            edge_det = stable & ~stable_d;
        end
    end

    assign wr_mask = avs_write && (avs_address == 2'd1);
    assign clr = (avs_write && (avs_address == 2'd3))
               ? avs_writedata[WIDTH-1:0] : '0;

    // Capture, mask and interrupt state; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d    <= '0;
            edgecapture <= '0;
            irqmask     <= '0;
            irq         <= 1'b0;
        end else begin
            stable_d    <= stable;
            edgecapture <= (edgecapture & ~clr) | edge_det;
            irq         <= |(edgecapture & irqmask);
            if (wr_mask) begin
                irqmask <= avs_writedata[WIDTH-1:0];
            end
        end
    end

    // Register read mux; unimplemented upper bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: rd_mux[WIDTH-1:0] = irqmask;
            2'd2: rd_mux[WIDTH-1:0] = s;
            default: rd_mux[WIDTH-1:0] = edgecapture;
        endcase
    end

    // Read data register: latency one, held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_input_capture.sv
// Directed bench for pio_input_capture: one instance with default polarity,
// one with inverted inputs and falling-edge capture.
module tb_pio_input_capture;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [1:0]  address;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [9:0]  in_a;
    logic [9:0]  in_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        irq_a;
    logic        irq_b;
    int          checks;
    int          errors;

    pio_input_capture #(
        .WIDTH(10), .DEBOUNCE_CYCLES(4),
        .INVERT_MASK(32'h0), .EDGE_TYPE(0)
    ) u_a (
        .clk(clk), .reset(rst_a),
        .avs_address(address), .avs_read(rd), .avs_write(wr),
        .avs_writedata(wdata), .avs_readdata(rdata_a),
        .in_port(in_a), .irq(irq_a)
    );

    pio_input_capture #(
        .WIDTH(10), .DEBOUNCE_CYCLES(4),
        .INVERT_MASK(32'h3FF), .EDGE_TYPE(1)
    ) u_b (
        .clk(clk), .reset(rst_b),
        .avs_address(address), .avs_read(rd), .avs_write(wr),
        .avs_writedata(wdata), .avs_readdata(rdata_b),
        .in_port(in_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_read(input logic [1:0] a,
                            output logic [31:0] da,
                            output logic [31:0] db);
        address = a;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        da = rdata_a;
        db = rdata_b;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        wdata = d;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] da, db;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), da, db);
            checks++;
            if (da !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr %0d got %h exp %h", a, da, 32'h0);
            end
        end
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b exp 0", irq_a);
        end
    endtask

    task automatic test_glitch;
        logic [31:0] da, db;
        in_a[3] = 1'b1;
        idle(2);
        address = 2'd2;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        in_a[3] = 1'b0;
        checks++;
        if (rdata_a !== 32'h008) begin
            errors++;
            $display("FAIL glitch_raw got %h exp %h", rdata_a, 32'h008);
        end
        idle(10);
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL glitch_data got %h exp %h", da, 32'h0);
        end
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL glitch_capture got %h exp %h", da, 32'h0);
        end
    endtask

    task automatic test_debounce_latency;
        logic [31:0] da, db;
        address = 2'd0;
        rd = 1'b1;
        in_a[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (rdata_a !== 32'h000) begin
                    errors++;
                    $display("FAIL latency_early got %h exp %h", rdata_a, 32'h0);
                end
            end
            if (k == 7) begin
                checks++;
                if (rdata_a !== 32'h001) begin
                    errors++;
                    $display("FAIL latency_on_time got %h exp %h", rdata_a, 32'h1);
                end
            end
        end
        rd = 1'b0;
        idle(2);
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h001) begin
            errors++;
            $display("FAIL rise_capture got %h exp %h", da, 32'h1);
        end
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq got %b exp 0", irq_a);
        end
        in_a[0] = 1'b0;
        idle(10);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL fall_no_capture got %h exp %h", da, 32'h0);
        end
    endtask

    task automatic test_regs;
        logic [31:0] da, db;
        bus_write(2'd0, 32'h3FF);
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL data_write_ignored got %h exp %h", da, 32'h0);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, da, db);
        checks++;
        if (da !== 32'h3FF) begin
            errors++;
            $display("FAIL mask_width got %h exp %h", da, 32'h3FF);
        end
        address = 2'd1;
        wdata = 32'h0;
        rd = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        checks++;
        if (rdata_a !== 32'h3FF) begin
            errors++;
            $display("FAIL rw_pre_write got %h exp %h", rdata_a, 32'h3FF);
        end
        bus_read(2'd1, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL rw_post_write got %h exp %h", da, 32'h0);
        end
    endtask

    task automatic test_irq;
        logic [31:0] da, db;
        bus_write(2'd1, 32'h1);
        in_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                checks++;
                if (irq_a !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_early got %b exp 0", irq_a);
                end
            end
            if (k == 8) begin
                checks++;
                if (irq_a !== 1'b1) begin
                    errors++;
                    $display("FAIL irq_assert got %b exp 1", irq_a);
                end
            end
        end
        bus_write(2'd3, 32'h0);
        idle(2);
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_clear_irq got %b exp 1", irq_a);
        end
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++;
            $display("FAIL zero_clear_capture got %h exp %h", da, 32'h1);
        end
        address = 2'd3;
        wdata = 32'h1;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL irq_reg_delay got %b exp 1", irq_a);
        end
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_deassert got %b exp 0", irq_a);
        end
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++;
            $display("FAIL w1c_capture got %h exp %h", da, 32'h0);
        end
    endtask

    task automatic test_set_wins;
        logic [31:0] da, db;
        in_a[0] = 1'b0;
        idle(10);
        in_a[0] = 1'b1;
        idle(10);
        in_a[0] = 1'b0;
        idle(10);
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_setup got %b exp 1", irq_a);
        end
        in_a[0] = 1'b1;
        idle(6);
        address = 2'd3;
        wdata = 32'h1;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_irq0 got %b exp 1", irq_a);
        end
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_irq1 got %b exp 1", irq_a);
        end
        bus_read(2'd3, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++;
            $display("FAIL set_wins_capture got %h exp %h", da, 32'h1);
        end
        bus_write(2'd3, 32'h1);
    endtask

    task automatic test_invert_falling;
        logic [31:0] da, db;
        rst_b = 1'b0;
        idle(4);
        in_b[1] = 1'b0;
        idle(10);
        bus_read(2'd0, da, db);
        checks++;
        if (db !== 32'h002) begin
            errors++;
            $display("FAIL inv_data got %h exp %h", db, 32'h002);
        end
        bus_read(2'd3, da, db);
        checks++;
        if (db !== 32'h000) begin
            errors++;
            $display("FAIL inv_no_capture got %h exp %h", db, 32'h0);
        end
        in_b[1] = 1'b1;
        idle(10);
        bus_read(2'd3, da, db);
        checks++;
        if (db !== 32'h002) begin
            errors++;
            $display("FAIL inv_fall_capture got %h exp %h", db, 32'h002);
        end
        in_b[2] = 1'b0;
        idle(3);
        rst_b = 1'b1;
        in_b = 10'h3FF;
        address = 2'd3;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        checks++;
        if (rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_pending_read got %h exp %h", rdata_b, 32'h0);
        end
        @(negedge clk);
        rst_b = 1'b0;
        for (int a = 0; a < 4; a++) begin
            if (a == 2) idle(4);
            bus_read(2'(a), da, db);
            checks++;
            if (db !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_read addr %0d got %h exp %h", a, db, 32'h0);
            end
        end
        checks++;
        if (irq_b !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_irq got %b exp 0", irq_b);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        address = 2'd0;
        rd      = 1'b0;
        wr      = 1'b0;
        wdata   = 32'h0;
        in_a    = 10'h000;
        in_b    = 10'h3FF;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        test_reset;
        test_glitch;
        test_debounce_latency;
        test_regs;
        test_irq;
        test_set_wins;
        test_invert_falling;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
